// File: rtl/imm_encoder.sv
// Immediate/instruction encoder with a 4-deep output FIFO and accept/error counters.
// Range checking and err/err_count are built only when IMM_ENCODER_RANGE_CHECK_EN is defined.
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [2:0]  count,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  localparam logic [2:0] F_I   = 3'd0;
  localparam logic [2:0] F_ISH = 3'd1;
  localparam logic [2:0] F_L   = 3'd2;
  localparam logic [2:0] F_S   = 3'd3;
  localparam logic [2:0] F_B   = 3'd4;
  localparam logic [2:0] F_U   = 3'd5;
  localparam logic [2:0] F_J   = 3'd6;

  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_U = 7'b0110111;
  localparam logic [6:0] OP_J = 7'b1101111;

  logic [31:0] enc_instr;
  logic        enc_err;

  always_comb begin
    enc_instr = 32'd0;
    case (fmt)
      F_I:     enc_instr = {imm[11:0], rs1, funct3, rd, OP_I};
      F_ISH:   enc_instr = {funct7, imm[4:0], rs1, funct3, rd, OP_I};
      F_L:     enc_instr = {imm[11:0], rs1, funct3, rd, OP_L};
      F_S:     enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
      F_B:     enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
      F_U:     enc_instr = {imm[31:12], rd, OP_U};
      F_J:     enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
      default: enc_instr = 32'd0;
    endcase
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  logic fits12, fits13, fits21;

  // A value fits in N signed bits when bits [31:N-1] are all copies of the sign.
  assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  always_comb begin
    enc_err = 1'b0;
    case (fmt)
      F_I, F_L, F_S: enc_err = ~fits12;
      F_ISH:         enc_err = (imm[31:5] != '0);
      F_B:           enc_err = ~fits13 | imm[0];
      F_U:           enc_err = (imm[11:0] != '0);
      F_J:           enc_err = ~fits21 | imm[0];
      default:       enc_err = 1'b1;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  logic [32:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic        rst_q;
  logic        push;
  logic        pop;

  // rst_q keeps in_ready low while reset is held, using registered state only.
  assign in_ready  = ~rst_q & (count < 3'd4);
  assign out_valid = (count != 3'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign instr     = out_valid ? mem[rd_ptr][31:0] : 32'd0;
  assign err       = out_valid & mem[rd_ptr][32];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_q     <= 1'b1;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 3'd0;
      enc_count <= 16'd0;
    end else begin
      rst_q <= 1'b0;
      if (push) begin
        wr_ptr    <= wr_ptr + 2'd1;
        enc_count <= enc_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enc_err, enc_instr};
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset)
      err_count <= 8'd0;
    else if (push && enc_err && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have a single clock domain; reset is synchronous and active-low.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- fmt  in  3  format: 0 I, 1 I-shift, 2 L, 3 S, 4 B, 5 U, 6 J, 7 illegal.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field, used by I-shift only.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- imm  in  32  immediate as a signed 32-bit value.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts the word.
- instr  out  32  encoded instruction.
- err  out  1  the immediate was not representable in the selected format.
- count  out  3  FIFO occupancy, 0..4.
- enc_count  out  16  accepted requests, wrapping.
- err_count  out  8  accepted requests with err=1, saturating.

Function
REQ-003 Opcodes SHALL be: I and I-shift 0010011, L 0000011, S 0100011, B 1100011, U 0110111, J 1101111; fmt 7 SHALL use opcode 0000000.
REQ-004 Field placement SHALL be:
- rd at [11:7] for I, I-shift, L, U, J.
- funct3 at [14:12] for I, I-shift, L, S, B.
- rs1 at [19:15] for I, I-shift, L, S, B.
- rs2 at [24:20] for S, B.
REQ-005 The immediate SHALL be placed as follows:
- I and L: [31:20]=imm[11:0].
- I-shift: [31:25]=funct7, [24:20]=imm[4:0].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- U: [31:12]=imm[31:12].
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-006 err SHALL be 1 when any of the following holds; otherwise err SHALL be 0:
- I, L or S: imm is outside the signed 12-bit range.
- I-shift: imm[31:5] is non-zero.
- B: imm is outside the signed 13-bit range, or imm[0]=1.
- U: imm[11:0] is non-zero.
- J: imm is outside the signed 21-bit range, or imm[0]=1.
- fmt is 7.
REQ-007 Encoding SHALL be combinational at acceptance; the pair {instr, err} SHALL be written into a 4-entry FIFO on the cycle in which in_valid and in_ready are both 1.
REQ-008 in_ready SHALL equal (count<4) and SHALL depend only on registered state; there is no pass-through when the FIFO is full, even if a pop occurs in the same cycle.
REQ-009 out_valid SHALL equal (count>0); instr and err SHALL present the FIFO head.
REQ-010 A word is popped when out_valid and out_ready are both 1; the head SHALL remain stable while out_valid=1 and out_ready=0.
REQ-011 Latency: a request accepted in cycle N SHALL appear at the output no earlier than cycle N+1; output order SHALL equal acceptance order.
REQ-012 On a simultaneous push and pop, count SHALL be unchanged and both operations SHALL take effect; read and write pointers SHALL wrap modulo 4.
REQ-013 enc_count SHALL increment on every accept and wrap from 0xFFFF to 0x0000.
REQ-014 err_count SHALL increment on every accept with err=1 and saturate at 0xFF.

Reset
REQ-015 While reset=0 at a clock edge, the block SHALL set count=0, both pointers=0, enc_count=0 and err_count=0.
REQ-016 During reset, out_valid=0, in_ready=0, instr=0 and err=0 SHALL hold; any queued entries SHALL be discarded, including when reset is asserted mid-operation.
REQ-017 in_ready SHALL assert in the first cycle after reset is released.

Configuration
REQ-018 The range checking of REQ-006 SHALL be controlled by the macro IMM_ENCODER_RANGE_CHECK_EN.
- When defined: err and err_count SHALL behave per REQ-006 and REQ-014.
- When undefined: err SHALL be constant 0 and err_count constant 0, imm bits outside the placement SHALL be silently truncated, and fmt 7 SHALL still produce opcode 0000000.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- U: fmt=5, rd=5, imm=0x12345000 -> instr=0x123452B7, err=0.
- I: fmt=0, funct3=0, rd=1, rs1=2, imm=0xFFFFFFFF -> instr=0xFFF10093, err=0.
- B: fmt=4, all regs 0, funct3=0, imm=0x00000800 -> instr=0x000000E3, err=0; imm=0x00001000 -> err=1.
- J: fmt=6, imm=3 -> err=1, err_count 0->1 (with the macro defined); err=0 with the macro undefined.
- out_ready=0, five back-to-back requests -> four accepted, in_ready=0, count=4; then out_ready=1 -> four words drain in order, one per cycle.
- count=2, reset=0 for one cycle -> out_valid=0, count=0, enc_count=0; the next request appears alone at the output.
